// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment number display.
// Segment vectors are indexed a..g as bits 0..6, active-low (0 = lit).
package seg7_pkg;

  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'b1111111;
  localparam seg7_t SEG7_MINUS = 7'b1111110;
  localparam seg7_t SEG7_E     = 7'b0110000;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    RENDER
  } seg7_state_e;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational BCD digit to active-low 7-segment glyph; non-decimal codes blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output seg7_t      seg
);

  // Decimal glyph lookup
  always_comb begin
    seg = SEG7_BLANK;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_number_display.sv
// Binary-to-decimal 7-segment display driver: iterative double-dabble conversion,
// leading-zero blanking, minus sign and overflow ("E") indication.
// Optional macro SEG7_BLINK_EN: blink the overflow image with half-period BLINK_DIV.
module seg7_number_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [DATA_W-1:0]            value,
  input  logic                         is_signed,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [NUM_DIGITS-1:0][0:6]   seg_n
);

  localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 2;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int CNT_W      = $clog2(DATA_W + 1);

  if (BLINK_DIV < 1) begin : g_blink_div_check
    $error("BLINK_DIV must be at least 1");
  end

  seg7_state_e                 state_q, state_d;
  logic [DATA_W-1:0]           mag_q, mag_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d;
  logic                        neg_q, neg_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][0:6]  img_q, img_d;

  logic                        neg_in;
  logic [DATA_W-1:0]           mag_in;
  logic [BCD_W-1:0]            bcd_adj, bcd_step;
  logic [DATA_W-1:0]           mag_step;
  logic [NUM_DIGITS-1:0][0:6]  glyph;
  logic [NUM_DIGITS-1:0][0:6]  img_new;
  logic                        ovf_new;
  int unsigned                 sig;
  int unsigned                 need;

  // Modulo-2^DATA_W negation already yields the exact magnitude of the most negative value.
  assign neg_in = is_signed & value[DATA_W-1];
  assign mag_in = neg_in ? ('0 - value) : value;

  // One double-dabble iteration: adjust nibbles >= 5, then shift {bcd,mag} left
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    {bcd_step, mag_step} = {bcd_adj, mag_q} << 1;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] nib;
    if (g < BCD_DIGITS) begin : g_nib
      assign nib = bcd_step[g*4 +: 4];
    end else begin : g_pad
      assign nib = 4'hF;
    end
    seg7_glyph u_glyph (
      .digit (nib),
      .seg   (glyph[g])
    );
  end

  // Display image from the finished BCD value (built on the last iteration's result)
  always_comb begin
    sig = 0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_step[i*4 +: 4] != 4'd0) sig = i;
    end
    need    = sig + 1 + (neg_q ? 1 : 0);
    img_new = '1;
    ovf_new = 1'b0;
    if (need > NUM_DIGITS) begin
      ovf_new    = 1'b1;
      img_new[0] = SEG7_E;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (i <= sig)                    img_new[i] = glyph[i];
        else if (neg_q && i == sig + 1)  img_new[i] = SEG7_MINUS;
      end
    end
  end

  // FSM next state: the final CONVERT cycle commits the image so done lands while busy is still high
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    img_d   = img_q;
    case (state_q)
      IDLE: begin
        if (load && !busy_q) begin
          state_d = CONVERT;
          neg_d   = neg_in;
          mag_d   = mag_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CONVERT: begin
        bcd_d = bcd_step;
        mag_d = mag_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = RENDER;
          img_d   = img_new;
          ovf_d   = ovf_new;
          done_d  = 1'b1;
        end
      end
      RENDER: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      img_q   <= '1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      img_q   <= img_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Free-running blink divider; phase toggles at each wrap
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Blink divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign seg_n = (ovf_q && !phase_q) ? '1 : img_q;
`else
  assign seg_n = img_q;
`endif

endmodule
